// File: rtl/sr_from_dff_reg.sv
// WIDTH-bit SR register built purely from D flops, with deterministic S=R=1 resolution
// and conflict reporting (registered flag, sticky flag, saturating counter).
module sr_from_dff_reg #(
  parameter int WIDTH         = 8,
  parameter int CONFLICT_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next state of one bit; out-of-range modes fall back to hold.
  function automatic logic sr_next(input logic q_b, input logic s_b, input logic r_b);
    logic nxt;
    case ({s_b, r_b})
      2'b00:   nxt = q_b;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      default: begin
        case (CONFLICT_MODE)
          1:       nxt = 1'b1;
          2:       nxt = 1'b0;
          3:       nxt = ~q_b;
          default: nxt = q_b;
        endcase
      end
    endcase
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] qbar_p1;
  logic             conflict_p1;
  logic             sticky_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [WIDTH-1:0] q_nxt_p0;
  logic             hit_p0;

  always_comb begin
    q_nxt_p0 = q_p1;
    hit_p0   = en & (|(s & r));
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_nxt_p0[i] = sr_next(q_p1[i], s[i], r[i]);
      end
    end
  end

  // ---- p0 -> p1 register boundary ----
  // qbar has its own flop fed with the complement of the same next state,
  // so it matches ~q on every cycle including reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1        <= '0;
      qbar_p1     <= '1;
      conflict_p1 <= 1'b0;
      sticky_p1   <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      q_p1        <= q_nxt_p0;
      qbar_p1     <= ~q_nxt_p0;
      conflict_p1 <= hit_p0;
      if (hit_p0) begin
        sticky_p1 <= 1'b1;
        cnt_p1    <= clr_err ? CNT_ONE : sat_inc(cnt_p1);
      end else if (clr_err) begin
        sticky_p1 <= 1'b0;
        cnt_p1    <= '0;
      end
    end
  end

  assign q               = q_p1;
  assign qbar            = qbar_p1;
  assign conflict        = conflict_p1;
  assign conflict_sticky = sticky_p1;
  assign conflict_cnt    = cnt_p1;

endmodule
